// File: rtl/alu_result_stage_pkg.sv
// Shared definitions for the execute-to-writeback stage: widths, opcodes,
// status bit positions, the writeback/branch record and the skid FSM states.
package alu_result_stage_pkg;

   localparam int WIDTH      = 16;
   localparam int REG_ADDR_W = 3;
   localparam int OPC_W      = 3;
   localparam int STATUS_W   = 5;

   localparam logic [OPC_W-1:0] OP_ADD  = 3'b000;
   localparam logic [OPC_W-1:0] OP_SUB  = 3'b001;
   localparam logic [OPC_W-1:0] OP_AND  = 3'b010;
   localparam logic [OPC_W-1:0] OP_OR   = 3'b011;
   localparam logic [OPC_W-1:0] OP_SLT  = 3'b100;
   localparam logic [OPC_W-1:0] OP_BNE  = 3'b101;
   localparam logic [OPC_W-1:0] OP_ADDI = 3'b110;
   localparam logic [OPC_W-1:0] OP_RSVD = 3'b111;

   // status = {Z,C,V,LT,GT}
   localparam int ST_Z  = 4;
   localparam int ST_C  = 3;
   localparam int ST_V  = 2;
   localparam int ST_LT = 1;
   localparam int ST_GT = 0;

   typedef struct packed {
      logic                  wb_en;
      logic [REG_ADDR_W-1:0] wb_addr;
      logic [WIDTH-1:0]      wb_data;
      logic                  br_taken;
      logic [WIDTH-1:0]      br_target;
   } rec_t;

   localparam int REC_W = $bits(rec_t);

   typedef enum logic [1:0] {
      SKID_EMPTY = 2'd0,
      SKID_ONE   = 2'd1,
      SKID_TWO   = 2'd2
   } skid_state_e;

   function automatic logic is_wb_op(input logic [OPC_W-1:0] op);
      return (op != OP_BNE) && (op != OP_RSVD);
   endfunction

endpackage

// File: rtl/alu_result_stage_if.sv
// Upstream instruction bus, downstream writeback/branch bus and status,
// bundled for the stage. slave = the stage, master = its environment.
interface alu_result_stage_if;
   import alu_result_stage_pkg::*;

   // Handshake: a beat transfers on the rising edge where valid && ready;
   // a producer holds valid and its data stable until that edge.
   logic                  in_valid;
   logic                  in_ready;
   logic [OPC_W-1:0]      in_opcode;
   logic [WIDTH-1:0]      in_result;
   logic                  in_cout;
   logic                  in_ov;
   logic                  in_lt;
   logic                  in_eq;
   logic                  in_gt;
   logic [REG_ADDR_W-1:0] in_dest;
   logic [WIDTH-1:0]      in_pc;
   logic [WIDTH-1:0]      in_imm;
   logic                  out_valid;
   logic                  out_ready;
   logic                  wb_en;
   logic [REG_ADDR_W-1:0] wb_addr;
   logic [WIDTH-1:0]      wb_data;
   logic                  br_taken;
   logic [WIDTH-1:0]      br_target;
   logic [STATUS_W-1:0]   status;
   skid_state_e           dbg_state;

   modport slave (
      input  in_valid, in_opcode, in_result, in_cout, in_ov, in_lt, in_eq, in_gt,
             in_dest, in_pc, in_imm, out_ready,
      output in_ready, out_valid, wb_en, wb_addr, wb_data, br_taken, br_target,
             status, dbg_state
   );

   modport master (
      output in_valid, in_opcode, in_result, in_cout, in_ov, in_lt, in_eq, in_gt,
             in_dest, in_pc, in_imm, out_ready,
      input  in_ready, out_valid, wb_en, wb_addr, wb_data, br_taken, br_target,
             status, dbg_state
   );

endinterface

// File: rtl/alu_result_stage_skid.sv
// Generic 2-entry valid/ready skid buffer; in_ready depends only on the
// state register, so there is no combinational path from out_ready.
module pipe_skid_buffer
   import alu_result_stage_pkg::*;
#(
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output skid_state_e       state_o
);

   skid_state_e       state_q, state_d;
   logic [DATA_W-1:0] main_q, main_d;
   logic [DATA_W-1:0] skid_q, skid_d;
   logic              accept;
   logic              drain;

   assign accept = in_valid && (state_q != SKID_TWO);
   assign drain  = (state_q != SKID_EMPTY) && out_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= SKID_EMPTY;
         main_q  <= '0;
         skid_q  <= '0;
      end else begin
         state_q <= state_d;
         main_q  <= main_d;
         skid_q  <= skid_d;
      end
   end

   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      case (state_q)
         SKID_EMPTY: begin
            if (accept) begin
               main_d  = in_data;
               state_d = SKID_ONE;
            end
         end
         SKID_ONE: begin
            if (accept && drain) begin
               main_d = in_data;
            end else if (accept) begin
               skid_d  = in_data;
               state_d = SKID_TWO;
            end else if (drain) begin
               state_d = SKID_EMPTY;
            end
         end
         SKID_TWO: begin
            // Older record sits in main; skid moves up so order is preserved.
            if (drain) begin
               main_d  = skid_q;
               state_d = SKID_ONE;
            end
         end
         default: state_d = SKID_EMPTY;
      endcase
   end

   assign in_ready  = (state_q != SKID_TWO);
   assign out_valid = (state_q != SKID_EMPTY);
   assign out_data  = main_q;
   assign state_o   = state_q;

endmodule

// File: rtl/alu_result_stage.sv
// Execute-to-writeback stage: decodes ALU results into writeback/branch
// records, keeps the sticky status register and buffers records in a skid.
module alu_result_stage
   import alu_result_stage_pkg::*;
#(
   parameter logic [WIDTH-1:0] PC_STEP = 1
) (
   input  logic               clk,
   input  logic               rst_n,
   alu_result_stage_if.slave  bus
);

   rec_t                rec_in;
   rec_t                rec_out;
   logic [WIDTH-1:0]    next_pc;
   logic [STATUS_W-1:0] status_q, status_d;
   logic                accept;
   logic                out_valid;

   assign accept  = bus.in_valid && bus.in_ready;
   assign next_pc = bus.in_pc + PC_STEP;

   always_comb begin
      rec_in           = '0;
      rec_in.br_target = next_pc;
      case (bus.in_opcode)
         OP_BNE: begin
            rec_in.br_taken = ~bus.in_eq;
            if (!bus.in_eq) rec_in.br_target = next_pc + bus.in_imm;
         end
         OP_RSVD: ;
         default: begin
            rec_in.wb_en   = 1'b1;
            rec_in.wb_addr = bus.in_dest;
            rec_in.wb_data = bus.in_result;
         end
      endcase
   end

   // Status follows instruction acceptance, not record retirement.
   always_comb begin
      status_d = status_q;
      if (accept) begin
         if (is_wb_op(bus.in_opcode)) status_d[ST_Z] = (bus.in_result == '0);
         if (bus.in_opcode == OP_ADD || bus.in_opcode == OP_SUB ||
             bus.in_opcode == OP_ADDI) begin
            status_d[ST_C] = bus.in_cout;
            status_d[ST_V] = bus.in_ov;
         end
         if (bus.in_opcode == OP_SLT || bus.in_opcode == OP_BNE) begin
            status_d[ST_LT] = bus.in_lt;
            status_d[ST_GT] = bus.in_gt;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) status_q <= '0;
      else        status_q <= status_d;
   end

   pipe_skid_buffer #(
      .DATA_W (REC_W)
   ) u_skid (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (bus.in_valid),
      .in_ready  (bus.in_ready),
      .in_data   (rec_in),
      .out_valid (out_valid),
      .out_ready (bus.out_ready),
      .out_data  (rec_out),
      .state_o   (bus.dbg_state)
   );

   // Side-effect strobes are qualified so an empty stage never asks for action.
   assign bus.out_valid = out_valid;
   assign bus.wb_en     = out_valid && rec_out.wb_en;
   assign bus.wb_addr   = rec_out.wb_addr;
   assign bus.wb_data   = rec_out.wb_data;
   assign bus.br_taken  = out_valid && rec_out.br_taken;
   assign bus.br_target = rec_out.br_target;
   assign bus.status    = status_q;

endmodule

// File: tb/tb_alu_result_stage.sv
// Directed + random bench for alu_result_stage with an expected-record queue.
module tb_alu_result_stage;
   import alu_result_stage_pkg::*;

   typedef struct {
      logic [2:0]  op;
      logic [15:0] result;
      logic        cout, ov, lt, eq, gt;
      logic [2:0]  dest;
      logic [15:0] pc, imm;
   } ins_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   alu_result_stage_if bus ();

   alu_result_stage #(.PC_STEP(16'd1)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int               n_chk = 0;
   int               n_pass = 0;
   int               rx_cnt = 0;
   int               rx0;
   logic [REC_W-1:0] exp_q[$];
   logic [4:0]       st_model = 5'b0;
   ins_t             cur;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      n_chk++;
      assert (obs === expv) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
   endtask

   function automatic ins_t mk(input logic [2:0] op, input logic [15:0] result,
                               input logic cout, input logic ov, input logic lt,
                               input logic eq, input logic gt, input logic [2:0] dest,
                               input logic [15:0] pc, input logic [15:0] imm);
      ins_t t;
      t.op = op; t.result = result; t.cout = cout; t.ov = ov; t.lt = lt;
      t.eq = eq; t.gt = gt; t.dest = dest; t.pc = pc; t.imm = imm;
      return t;
   endfunction

   function automatic logic [REC_W-1:0] exp_rec(input ins_t t);
      logic [15:0] npc;
      npc = t.pc + 16'd1;
      case (t.op)
         3'b101:  return {1'b0, 3'b0, 16'h0, ~t.eq, (t.eq ? npc : npc + t.imm)};
         3'b111:  return {1'b0, 3'b0, 16'h0, 1'b0, npc};
         default: return {1'b1, t.dest, t.result, 1'b0, npc};
      endcase
   endfunction

   function automatic logic [4:0] st_next(input ins_t t, input logic [4:0] s);
      logic [4:0] n;
      n = s;
      if (t.op != 3'b101 && t.op != 3'b111) n[4] = (t.result == 16'h0);
      if (t.op == 3'b000 || t.op == 3'b001 || t.op == 3'b110) begin
         n[3] = t.cout; n[2] = t.ov;
      end
      if (t.op == 3'b100 || t.op == 3'b101) begin
         n[1] = t.lt; n[0] = t.gt;
      end
      return n;
   endfunction

   function automatic ins_t rnd_ins();
      return mk(3'($urandom_range(0, 7)), 16'($urandom_range(0, 65535)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)));
   endfunction

   // Drivers: inputs change 1 time unit after the rising edge.
   task automatic drive(input ins_t t);
      @(posedge clk);
      #1;
      cur           = t;
      bus.in_valid  = 1'b1;
      bus.in_opcode = t.op;
      bus.in_result = t.result;
      bus.in_cout   = t.cout;
      bus.in_ov     = t.ov;
      bus.in_lt     = t.lt;
      bus.in_eq     = t.eq;
      bus.in_gt     = t.gt;
      bus.in_dest   = t.dest;
      bus.in_pc     = t.pc;
      bus.in_imm    = t.imm;
   endtask

   // Returns on the falling edge just before the accepting rising edge.
   task automatic wait_accept();
      int n;
      n = 0;
      while (n < 50) begin
         @(negedge clk);
         if (bus.in_ready) begin
            exp_q.push_back(exp_rec(cur));
            st_model = st_next(cur, st_model);
            return;
         end
         n++;
      end
      chk("accept_timeout", 64'(bus.in_ready), 64'd1);
   endtask

   task automatic send(input ins_t t);
      drive(t);
      wait_accept();
   endtask

   task automatic idle();
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
   endtask

   task automatic set_out_ready(input logic r);
      @(posedge clk);
      #1;
      bus.out_ready = r;
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("drain_queue_empty", 64'(exp_q.size()), 64'd0);
   endtask

   // Scoreboard: pop and compare each record the DUT hands over.
   always @(negedge clk) begin
      logic [REC_W-1:0] obs;
      logic [REC_W-1:0] e;
      if (rst_n && bus.out_valid && bus.out_ready) begin
         obs = {bus.wb_en, bus.wb_addr, bus.wb_data, bus.br_taken, bus.br_target};
         if (exp_q.size() == 0) begin
            chk("out_with_empty_queue", 64'(exp_q.size()), 64'd1);
         end else begin
            e = exp_q.pop_front();
            chk("record", 64'(obs), 64'(e));
            rx_cnt++;
         end
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      ins_t t;
      bus.in_valid = 1'b0; bus.in_opcode = '0; bus.in_result = '0; bus.in_cout = 1'b0;
      bus.in_ov = 1'b0; bus.in_lt = 1'b0; bus.in_eq = 1'b0; bus.in_gt = 1'b0;
      bus.in_dest = '0; bus.in_pc = '0; bus.in_imm = '0; bus.out_ready = 1'b1;

      // Reset values
      #12;
      chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
      chk("rst_status", 64'(bus.status), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
      chk("rst_wb_en", 64'(bus.wb_en), 64'd0);
      chk("rst_br_taken", 64'(bus.br_taken), 64'd0);
      chk("rst_wb_addr", 64'(bus.wb_addr), 64'd0);
      chk("rst_wb_data", 64'(bus.wb_data), 64'd0);
      chk("rst_br_target", 64'(bus.br_target), 64'd0);

      // add giving zero with carry out
      send(mk(3'b000, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd3, 16'h0010, 16'h0));
      idle();
      @(negedge clk);
      chk("add_out_valid", 64'(bus.out_valid), 64'd1);
      chk("add_wb_en", 64'(bus.wb_en), 64'd1);
      chk("add_wb_addr", 64'(bus.wb_addr), 64'd3);
      chk("add_wb_data", 64'(bus.wb_data), 64'd0);
      chk("add_status", 64'(bus.status), 64'(5'b11000));

      // bne taken with target wrap, then not taken
      send(mk(3'b101, 16'h1234, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd6, 16'hFFFE, 16'h0003));
      idle();
      @(negedge clk);
      chk("bne_t_wb_en", 64'(bus.wb_en), 64'd0);
      chk("bne_t_taken", 64'(bus.br_taken), 64'd1);
      chk("bne_t_target", 64'(bus.br_target), 64'h0002);
      chk("bne_t_status", 64'(bus.status), 64'(5'b11001));
      send(mk(3'b101, 16'h1234, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd6, 16'hFFFE, 16'h0003));
      idle();
      @(negedge clk);
      chk("bne_nt_taken", 64'(bus.br_taken), 64'd0);
      chk("bne_nt_target", 64'(bus.br_target), 64'hFFFF);
      chk("bne_nt_status", 64'(bus.status), 64'(5'b11000));

      // reserved opcode between two adds
      send(mk(3'b000, 16'h0005, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd1, 16'h0020, 16'h0));
      idle();
      @(negedge clk);
      chk("add1_status", 64'(bus.status), 64'(5'b00100));
      send(mk(3'b111, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 3'd2, 16'h0021, 16'h0));
      idle();
      @(negedge clk);
      chk("rsvd_out_valid", 64'(bus.out_valid), 64'd1);
      chk("rsvd_wb_en", 64'(bus.wb_en), 64'd0);
      chk("rsvd_br_taken", 64'(bus.br_taken), 64'd0);
      chk("rsvd_status", 64'(bus.status), 64'(5'b00100));
      send(mk(3'b000, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd2, 16'h0022, 16'h0));
      idle();
      @(negedge clk);
      chk("add2_status", 64'(bus.status), 64'(5'b11000));
      wait_drain();

      // back-pressure: A, B fill the stage, C is held off
      rx0 = rx_cnt;
      set_out_ready(1'b0);
      send(mk(3'b000, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1, 16'h0100, 16'h0));
      send(mk(3'b001, 16'h0002, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd2, 16'h0101, 16'h0));
      drive(mk(3'b100, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd4, 16'h0102, 16'h0));
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("bp_in_ready_low", 64'(bus.in_ready), 64'd0);
         chk("bp_state_two", 64'(bus.dbg_state), 64'(SKID_TWO));
         chk("bp_hold_data", 64'(bus.wb_data), 64'h0001);
         chk("bp_status_hold", 64'(bus.status), 64'(st_model));
      end
      set_out_ready(1'b1);
      wait_accept();
      idle();
      wait_drain();
      chk("bp_rx_count", 64'(rx_cnt - rx0), 64'd3);
      @(negedge clk);
      chk("bp_status_after", 64'(bus.status), 64'(st_model));

      // full-throughput random stream
      rx0 = rx_cnt;
      for (int i = 0; i < 100; i++) begin
         t = rnd_ins();
         drive(t);
         @(negedge clk);
         chk("tput_in_ready", 64'(bus.in_ready), 64'd1);
         if (i > 0) chk("tput_out_valid", 64'(bus.out_valid), 64'd1);
         if (bus.in_ready) begin
            exp_q.push_back(exp_rec(cur));
            st_model = st_next(cur, st_model);
         end else begin
            wait_accept();
         end
      end
      idle();
      wait_drain();
      chk("tput_rx_count", 64'(rx_cnt - rx0), 64'd100);
      @(negedge clk);
      chk("tput_status", 64'(bus.status), 64'(st_model));

      // reset with two records buffered
      set_out_ready(1'b0);
      send(mk(3'b010, 16'h00F0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd5, 16'h0200, 16'h0));
      send(mk(3'b011, 16'h0F00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd6, 16'h0201, 16'h0));
      idle();
      @(negedge clk);
      chk("mid_out_valid_pre", 64'(bus.out_valid), 64'd1);
      chk("mid_in_ready_pre", 64'(bus.in_ready), 64'd0);
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_out_valid", 64'(bus.out_valid), 64'd0);
      chk("mid_rst_status", 64'(bus.status), 64'd0);
      chk("mid_rst_wb_en", 64'(bus.wb_en), 64'd0);
      exp_q.delete();
      st_model = 5'b0;
      @(negedge clk);
      rst_n = 1'b1;
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      chk("mid_rel_in_ready", 64'(bus.in_ready), 64'd1);
      chk("mid_rel_out_valid", 64'(bus.out_valid), 64'd0);
      send(mk(3'b110, 16'h0007, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd5, 16'h0300, 16'h0));
      idle();
      wait_drain();
      @(negedge clk);
      chk("post_rst_status", 64'(bus.status), 64'(st_model));

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
